// File: rtl/pq_pkg.sv
// -----------------------------------------------------------------------------
// pq_pkg
// Shared types and helpers for the register-array priority queues.
//   KEY_WIDTH / VAL_WIDTH : default key and payload widths
//   PQ_DEPTH              : default queue depth
//   kv_t                  : packed {key, val} entry
//   cell_sel_t            : next-value source for one queue slot
//   higher_prio()         : strict priority compare between two keys
// -----------------------------------------------------------------------------
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam int PQ_DEPTH  = 8;

    // Keys are zero-extended to this width before comparing, so the same
    // helper serves any queue instance whose key is narrower than this.
    localparam int CMP_WIDTH = 64;

    typedef logic [KEY_WIDTH-1:0] key_t;
    typedef logic [VAL_WIDTH-1:0] val_t;

    typedef struct packed {
        key_t key;
        val_t val;
    } kv_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LEFT  = 2'd1,
        SEL_LOAD  = 2'd2,
        SEL_RIGHT = 2'd3
    } cell_sel_t;

    // Returns 1 when key a is strictly higher priority than key b.
    function automatic logic higher_prio(input logic [CMP_WIDTH-1:0] a,
                                         input logic [CMP_WIDTH-1:0] b,
                                         input logic                 max_first);
        return max_first ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/ra_pq_param_cell.sv
// -----------------------------------------------------------------------------
// ra_pq_cell
// One slot of the register-array priority queue.
//   clk, rst               : clock, async active-high reset
//   op_enq/op_deq/op_repl  : decoded operation for this edge (one-hot or none)
//   new_kv                 : entry being inserted
//   beat_left/beat_right   : neighbours' "new entry beats me" flags
//   left_*/right_*         : neighbours' stored contents
//   valid, kv              : this slot's registered contents
//   beat                   : new entry is strictly higher priority than this
//                            slot (always 1 for an empty slot)
// -----------------------------------------------------------------------------
module ra_pq_cell
    import pq_pkg::*;
#(
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter int MAX_FIRST = 0,
    parameter bit IS_HEAD   = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           op_enq,
    input  logic                           op_deq,
    input  logic                           op_repl,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] new_kv,
    input  logic                           beat_left,
    input  logic                           beat_right,
    input  logic                           left_valid,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] left_kv,
    input  logic                           right_valid,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] right_kv,
    output logic                           valid,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kv,
    output logic                           beat
);

    localparam int KVW = KEY_WIDTH + VAL_WIDTH;

    logic [CMP_WIDTH-1:0] new_key_ext;
    logic [CMP_WIDTH-1:0] own_key_ext;
    cell_sel_t            sel;

    assign new_key_ext = CMP_WIDTH'(new_kv[KVW-1:VAL_WIDTH]);
    assign own_key_ext = CMP_WIDTH'(kv[KVW-1:VAL_WIDTH]);

    // Strict compare: an equal key does not beat us, so ties keep arrival order.
    assign beat = !valid || higher_prio(new_key_ext, own_key_ext, MAX_FIRST != 0);

    // Slots are sorted, so the beat flags form a run of 0s followed by 1s and
    // the insertion point is where that run starts.
    // Replace: the head leaves and everything ahead of the insertion point
    // moves one slot toward the head; the new entry lands just before the
    // first beaten slot; slots past it keep their contents (shift and
    // insertion cancel out).
    always_comb begin
        sel = SEL_HOLD;
        if (op_enq) begin
            if (beat_left) begin
                sel = SEL_LEFT;
            end else if (beat) begin
                sel = SEL_LOAD;
            end
        end else if (op_deq) begin
            sel = SEL_RIGHT;
        end else if (op_repl) begin
            if (!beat_right) begin
                sel = SEL_RIGHT;
            end else if (IS_HEAD || !beat) begin
                sel = SEL_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            kv    <= '0;
        end else begin
            case (sel)
                SEL_LEFT: begin
                    valid <= left_valid;
                    kv    <= left_kv;
                end
                SEL_LOAD: begin
                    valid <= 1'b1;
                    kv    <= new_kv;
                end
                SEL_RIGHT: begin
                    valid <= right_valid;
                    kv    <= right_kv;
                end
                default: begin
                    valid <= valid;
                    kv    <= kv;
                end
            endcase
        end
    end

endmodule

// File: rtl/ra_pq_param.sv
// -----------------------------------------------------------------------------
// ra_pq_param
// Parametrised register-array priority queue with stable ordering for equal
// keys, drop-lowest overflow policy and underflow reporting.
//   clk, rst    : clock, async active-high reset
//   enq, kvi    : insert {key,val}
//   deq         : remove head (kvo is the entry removed at the edge)
//   kvo, ovalid : registered head entry and its valid flag
//   empty, full, count : registered occupancy
//   drop_valid, drop_kv : one-cycle pulse + entry discarded on overflow
//   underflow   : one-cycle pulse for deq on an empty queue without enq
// -----------------------------------------------------------------------------
module ra_pq_param
    import pq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter int MAX_FIRST = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           ovalid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           drop_valid,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] drop_kv,
    output logic                           underflow
);

    localparam int KVW = KEY_WIDTH + VAL_WIDTH;
    localparam int CW  = $clog2(DEPTH+1);

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_beat;
    logic [KVW-1:0]   slot_kv [DEPTH];

    logic             op_enq;
    logic             op_deq;
    logic             op_repl;
    logic [CW-1:0]    count_nxt;

    // enq+deq on an empty queue degenerates to a plain insert.
    assign op_repl = enq && deq && !empty;
    assign op_enq  = enq && !op_repl;
    assign op_deq  = deq && !enq && !empty;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic           beat_l;
        logic           beat_r;
        logic           valid_l;
        logic           valid_r;
        logic [KVW-1:0] kv_l;
        logic [KVW-1:0] kv_r;

        if (i == 0) begin : g_head
            assign beat_l  = 1'b0;
            assign valid_l = 1'b0;
            assign kv_l    = '0;
        end else begin : g_mid_l
            assign beat_l  = slot_beat[i-1];
            assign valid_l = slot_valid[i-1];
            assign kv_l    = slot_kv[i-1];
        end

        // Past the tail behaves like an always-beaten empty slot.
        if (i == DEPTH-1) begin : g_tail
            assign beat_r  = 1'b1;
            assign valid_r = 1'b0;
            assign kv_r    = '0;
        end else begin : g_mid_r
            assign beat_r  = slot_beat[i+1];
            assign valid_r = slot_valid[i+1];
            assign kv_r    = slot_kv[i+1];
        end

        ra_pq_cell #(
            .KEY_WIDTH (KEY_WIDTH),
            .VAL_WIDTH (VAL_WIDTH),
            .MAX_FIRST (MAX_FIRST),
            .IS_HEAD   (i == 0)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .op_enq      (op_enq),
            .op_deq      (op_deq),
            .op_repl     (op_repl),
            .new_kv      (kvi),
            .beat_left   (beat_l),
            .beat_right  (beat_r),
            .left_valid  (valid_l),
            .left_kv     (kv_l),
            .right_valid (valid_r),
            .right_kv    (kv_r),
            .valid       (slot_valid[i]),
            .kv          (slot_kv[i]),
            .beat        (slot_beat[i])
        );
    end

    assign kvo    = slot_kv[0];
    assign ovalid = slot_valid[0];

    always_comb begin
        count_nxt = count;
        if (op_enq && !full) begin
            count_nxt = count + CW'(1);
        end else if (op_deq) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            drop_valid <= 1'b0;
            drop_kv    <= '0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_nxt;
            empty      <= (count_nxt == '0);
            full       <= (count_nxt == CW'(DEPTH));
            underflow  <= deq && !enq && empty;
            drop_valid <= 1'b0;
            if (op_enq && full) begin
                drop_valid <= 1'b1;
                // The tail falls off only if the newcomer outranks it;
                // otherwise the newcomer itself is rejected.
                drop_kv    <= slot_beat[DEPTH-1] ? slot_kv[DEPTH-1] : kvi;
            end
        end
    end

endmodule

// File: doc/ra_pq_param.md
Name: ra_pq_param

Overview:
Parametrised register-array priority queue, the successor to the fixed 4-entry register-array PQ. It adds configurable depth, min-first or max-first ordering, and stable FIFO ordering among equal keys. It also adds an occupancy count, a defined overflow policy that drops the lowest-priority entry and reports it, and an underflow indication. It sits behind pq_if in place of the fixed-depth PQ and is driven by the existing enq/deq testbench tasks.

Parameters:
DEPTH, 8, number of entries (>=2)
KEY_WIDTH, pq_pkg::KEY_WIDTH, key bits (lower value = higher priority when MAX_FIRST=0)
VAL_WIDTH, pq_pkg::VAL_WIDTH, payload bits
MAX_FIRST, 0, 1 = larger key has higher priority

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
enq  in  1  insert kvi this cycle
deq  in  1  remove head this cycle
kvi  in  KEY_WIDTH+VAL_WIDTH  {key,val} to insert
kvo  out  KEY_WIDTH+VAL_WIDTH  head entry, valid when ovalid=1
ovalid  out  1  head valid (= !empty)
empty  out  1  count==0
full  out  1  count==DEPTH
count  out  $clog2(DEPTH+1)  occupancy
drop_valid  out  1  one-cycle pulse: an entry was discarded on overflow
drop_kv  out  KEY_WIDTH+VAL_WIDTH  discarded entry, valid with drop_valid
underflow  out  1  one-cycle pulse: deq while empty without enq

Behaviour:
- Reset (async assert, sync release):
  - all slots invalid, kvo=0, count=0, empty=1, full=0, ovalid=0, drop_valid=0, drop_kv=0, underflow=0.
  - Reset mid-operation discards all contents immediately.
- Storage: slot 0 is the head; valid slots are contiguous from 0 and sorted by priority.
- Outputs: kvo, empty, full, count and ovalid are driven directly from registers. They are never combinational from inputs.
- Show-ahead: kvo before an edge is the item consumed by deq at that edge. An enq at edge k is visible on kvo/count after edge k.
- Stable ordering: a new entry is inserted at the first slot whose key is strictly lower priority. Equal keys therefore leave in arrival order.
- Operations per edge:
  - enq only, not full: insert; count+1.
  - enq only, full, new key strictly higher priority than tail: tail (slot DEPTH-1) is discarded and the new entry inserted. drop_valid=1 and drop_kv=old tail; count unchanged.
  - enq only, full, otherwise: new entry discarded, drop_valid=1, drop_kv=kvi; contents unchanged.
  - deq only, not empty: shift slots toward head; count-1.
  - deq only, empty: no state change; underflow=1 for one cycle.
  - enq+deq, not empty (replace): head removed and kvi inserted into the remaining entries in one edge; count unchanged. Legal when full; never drops.
  - enq+deq, empty: treated as enq only; no underflow.
- drop_valid and underflow are registered and high for exactly the cycle after the causing edge. drop_kv holds its value until the next drop.
- Priority compare: unsigned; MAX_FIRST selects the direction. Only keys are compared; values are never compared.

Decomposition:
- pq_pkg gains:
  - typedef kv_t (packed {key,val}, parametrised by package widths);
  - function higher_prio(a, b, max_first) returning strict priority;
  - localparam default PQ_DEPTH.
- One sub-module, ra_pq_cell, holds one slot (valid, kv). It selects among hold / shift-from-left-neighbour / load-kvi / shift-from-right-neighbour using its own compare result and its neighbours' results. ra_pq_param instantiates DEPTH cells with a generate loop plus count/flag logic.

Test Plan:
1. DEPTH=4, MAX_FIRST=0: enq (8,14),(11,11),(9,9),(10,10) -> full=1, count=4. Four deqs -> kvo keys 8,9,10,11 with vals 14,9,10,11, then empty=1.
2. Ties: enq (9,10),(9,11),(9,12) -> deq order vals 10,11,12.
3. Overflow, DEPTH=4:
   - contents keys 1,2,3,4; enq (2,7) -> drop_valid pulse with drop_kv key 4; contents 1,2,2(val 7),3.
   - then enq key 5 -> drop_kv = {5,val}; contents unchanged; count stays 4.
4. Replace:
   - contents 8,9,10; enq+deq (12,12) -> consumes 8; contents 9,10,12; count 3.
   - from empty, enq+deq (5,5) -> count 1, kvo key 5, underflow=0.
5. Underflow and reset:
   - deq on empty -> underflow high for one cycle; count 0.
   - assert rst mid-cycle with 3 entries -> empty=1 and count=0 without waiting for a clock edge.
6. MAX_FIRST=1: enq keys 3,7,5 -> deq order 7,5,3. Full overflow with key 1 -> key 1 itself dropped.
